// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect from execute,
// and the valid/ready queue output toward decode.
interface fetch_if;
  logic [18:0] imem_addr;
  logic [18:0] imem_instr;
  logic        redirect_valid;
  logic [18:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_instr;
  logic [18:0] out_pc;
  logic        halted;

  // master: the fetch unit itself
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  // slave: memory + execute + decode side
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register driving imem, 2-entry {pc, instr} queue
// toward decode, redirect from execute, and stop-on-HALT.
module fetch_unit #(
  parameter logic [18:0] RESET_PC    = 19'd0,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic [18:0] pc;
    logic [18:0] instr;
  } entry_t;

  state_t      r_state;
  logic [18:0] r_pc;
  logic [1:0]  r_count;
  entry_t      r_head;
  entry_t      r_tail;

  logic        w_pop;
  logic        w_fetch;
  logic        w_is_halt;
  entry_t      w_new;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_pop     = 1'b0;
    w_fetch   = 1'b0;
    w_is_halt = 1'b0;
    w_new     = '{pc: r_pc, instr: bus.imem_instr};
    w_pop     = (r_count != 2'd0) && bus.out_ready;
    // A full queue can still accept a fetch when its head leaves this cycle.
    w_fetch   = (r_state == S_RUN) && !bus.redirect_valid &&
                ((r_count < 2'd2) || bus.out_ready);
    w_is_halt = (bus.imem_instr[18:15] == HALT_OPCODE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= 2'd0;
      r_state <= S_RUN;
    end else if (bus.redirect_valid) begin
      r_pc    <= bus.redirect_pc;
      r_count <= 2'd0;
      r_state <= S_RUN;
    end else begin
      if (w_fetch) begin
        r_pc <= r_pc + 19'd1;
        if (w_is_halt) r_state <= S_HALT;
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue payload has no reset; r_count alone says which entries are
  // live, and the output mux zeroes the bus while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid) begin
      if (w_pop) begin
        r_head <= (w_fetch && (r_count == 2'd1)) ? w_new : r_tail;
        if (w_fetch) r_tail <= w_new;
      end else if (w_fetch) begin
        if (r_count == 2'd0) r_head <= w_new;
        else                 r_tail <= w_new;
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_instr = bus.out_valid ? r_head.instr : 19'd0;
  assign bus.out_pc    = bus.out_valid ? r_head.pc    : 19'd0;
  assign bus.halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector tables from the test plan, a wrap-around
// sequence on a second instance, then random traffic against a queue model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if bus2 ();

  fetch_unit #(.RESET_PC(19'd0), .HALT_OPCODE(4'b1111)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  fetch_unit #(.RESET_PC(19'h7FFFE), .HALT_OPCODE(4'b1111)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  logic [18:0] prog [64];
  always_comb bus.imem_instr = prog[bus.imem_addr[5:0]];
  assign bus2.imem_instr = {4'h3, bus2.imem_addr[14:0]};

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    bit          rv;
    logic [18:0] rpc;
    bit          rdy;
    bit          chk;
    bit          ev;
    logic [18:0] epc;
    logic [18:0] ein;
    bit          eh;
    logic [18:0] ea;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [18:0] pc;
    logic [18:0] instr;
  } ment_t;

  ment_t       mq[$];
  logic [18:0] m_pc;
  bit          m_halt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(bit r, bit rv, int rpc, bit rdy, bit chk, bit ev, int epc,
                     bit eh, int ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = 19'(rpc); v.rdy = rdy; v.chk = chk;
    v.ev = ev; v.epc = ev ? 19'(epc) : 19'd0;
    v.ein = ev ? prog[epc[5:0]] : 19'd0;
    v.eh = eh; v.ea = 19'(ea);
    vecs.push_back(v);
  endtask

  task automatic drive(bit r, bit rv, logic [18:0] rpc, bit rdy);
    @(negedge clk);
    rst = r;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic check_outputs(string tag, bit ev, logic [18:0] epc,
                               logic [18:0] ein, bit eh, logic [18:0] ea);
    check({tag, ".valid"},  32'(bus.out_valid), 32'(ev));
    check({tag, ".pc"},     32'(bus.out_pc),    32'(epc));
    check({tag, ".instr"},  32'(bus.out_instr), 32'(ein));
    check({tag, ".halted"}, 32'(bus.halted),    32'(eh));
    check({tag, ".addr"},   32'(bus.imem_addr), 32'(ea));
  endtask

  task automatic run_vectors(string tname);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      if (vecs[i].chk)
        check_outputs($sformatf("%s[%0d]", tname, i), vecs[i].ev, vecs[i].epc,
                      vecs[i].ein, vecs[i].eh, vecs[i].ea);
    end
    vecs.delete();
  endtask

  // Reference behaviour for one clock edge, from the queue's rules.
  task automatic model_step(bit r, bit rv, logic [18:0] rpc, bit rdy);
    bit popped;
    bit do_fetch;
    ment_t e;
    if (r) begin
      mq.delete(); m_pc = 19'd0; m_halt = 0;
    end else if (rv) begin
      mq.delete(); m_pc = rpc; m_halt = 0;
    end else begin
      popped = (mq.size() > 0) && rdy;
      do_fetch = !m_halt && ((mq.size() - int'(popped)) < 2);
      if (popped) void'(mq.pop_front());
      if (do_fetch) begin
        e.pc = m_pc;
        e.instr = prog[m_pc[5:0]];
        mq.push_back(e);
        m_pc = m_pc + 19'd1;
        if (e.instr[18:15] == 4'b1111) m_halt = 1;
      end
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 19'd0;
    bus.out_ready = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = 19'd0;
    bus2.out_ready = 1'b1;

    prog[0] = 19'h00013;
    prog[1] = 19'b0001010001000000101;
    prog[2] = 19'h10022;
    prog[3] = 19'h20033;
    prog[4] = 19'h30044;
    prog[5] = 19'b1111000000000000000;
    for (int i = 6; i < 64; i++) prog[i] = {4'h2, 15'(i)};

    // Free-run to HALT, then redirect out of HALT to pc 2.
    //  rst rv rpc rdy chk ev pc halt addr
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 0, 2);
    add(0, 0, 0, 1, 1, 1, 2, 0, 3);
    add(0, 0, 0, 1, 1, 1, 3, 0, 4);
    add(0, 0, 0, 1, 1, 1, 4, 0, 5);
    add(0, 0, 0, 1, 1, 1, 5, 1, 6);
    add(0, 0, 0, 1, 1, 0, 0, 1, 6);
    add(0, 0, 0, 1, 1, 0, 0, 1, 6);
    add(0, 1, 2, 1, 1, 0, 0, 1, 6);
    add(0, 0, 0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 0, 1, 1, 1, 2, 0, 3);
    add(0, 0, 0, 1, 1, 1, 3, 0, 4);
    add(0, 0, 0, 1, 1, 1, 4, 0, 5);
    add(0, 0, 0, 1, 1, 1, 5, 1, 6);
    add(0, 0, 0, 1, 1, 0, 0, 1, 6);
    run_vectors("freerun");

    // Backpressure, redirect while full {3,4}, then reset with count=2 in HALT.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 2);
    add(0, 0, 0, 0, 1, 1, 0, 0, 2);
    add(0, 0, 0, 1, 1, 1, 0, 0, 2);
    add(0, 0, 0, 1, 1, 1, 1, 0, 3);
    add(0, 0, 0, 1, 1, 1, 2, 0, 4);
    add(0, 1, 1, 1, 1, 1, 3, 0, 5);
    add(0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 0, 2);
    add(0, 0, 0, 0, 1, 1, 2, 0, 3);
    add(0, 0, 0, 1, 1, 1, 2, 0, 4);
    add(0, 0, 0, 1, 1, 1, 3, 0, 5);
    add(1, 0, 0, 0, 1, 1, 4, 1, 6);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_vectors("bp");

    // Wrap-around on the instance reset to 7FFFE.
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk); rst2 = 1'b0; #1;
    check("wrap.addr0", 32'(bus2.imem_addr), 32'h7FFFE);
    check("wrap.valid0", 32'(bus2.out_valid), 32'd0);
    begin
      logic [18:0] exp_pc [3];
      exp_pc[0] = 19'h7FFFE; exp_pc[1] = 19'h7FFFF; exp_pc[2] = 19'h00000;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); #1;
        check($sformatf("wrap.pc%0d", i), 32'(bus2.out_pc), 32'(exp_pc[i]));
        check($sformatf("wrap.instr%0d", i), 32'(bus2.out_instr),
              32'({4'h3, exp_pc[i][14:0]}));
      end
    end

    // Random traffic with HALT words sprinkled through the program.
    for (int i = 0; i < 64; i++)
      prog[i] = ($urandom_range(0, 9) == 0) ? {4'hF, 15'($urandom)}
                                             : {4'($urandom_range(0, 14)), 15'($urandom)};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, rv, rdy;
      logic [18:0] rpc;
      r = (cyc == 0) || ($urandom_range(0, 149) == 0);
      rv = ($urandom_range(0, 11) == 0);
      rpc = 19'($urandom_range(0, 63));
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, rv, rpc, rdy);
      if (cyc > 0)
        check_outputs($sformatf("rand[%0d]", cyc), mq.size() != 0,
                      mq.size() != 0 ? mq[0].pc : 19'd0,
                      mq.size() != 0 ? mq[0].instr : 19'd0, m_halt, m_pc);
      model_step(r, rv, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
